ifu_fetch_queue: RTL and testbench

Instruction-fetch front end between instruction memory and the decode stage. Generates sequential fetch addresses, issues them to memory over a valid/ready request channel, and collects the in-order responses in a small queue. Delivers (pc, inst) pairs to decode over a valid/ready channel. Supports a one-cycle redirect that flushes the queue and discards in-flight responses.

---
 rtl/ifu_fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_ifu_fetch_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: sequential fetch-address generator, in-order
// response queue, and a one-cycle redirect that flushes the queue and drops
// responses still in flight.

// One queue slot: holds {pc, inst, filled} for a single fetch.
module ifu_fq_entry (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_en_i,
  input  logic [31:0] pc_i,
  input  logic        fill_en_i,
  input  logic [31:0] inst_i,
  input  logic        pop_en_i,
  input  logic        flush_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        filled_o
);
  logic [31:0] pc_q, pc_d, inst_q, inst_d;
  logic        filled_q, filled_d;

  // Slot update: allocate, pop, fill, with flush overriding the filled bit.
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    filled_d = filled_q;
    if (alloc_en_i) begin
      pc_d     = pc_i;
      filled_d = 1'b0;
    end
    if (pop_en_i)  filled_d = 1'b0;
    if (fill_en_i) begin
      inst_d   = inst_i;
      filled_d = 1'b1;
    end
    if (flush_i)   filled_d = 1'b0;
  end

  // Slot registers; pc/inst reset to 0 so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      inst_q   <= '0;
      filled_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      filled_q <= filled_d;
    end
  end

  assign pc_o     = pc_q;
  assign inst_o   = inst_q;
  assign filled_o = filled_q;
endmodule

module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] alloc_q, alloc_d, fill_q, fill_d, rd_q, rd_d, drop_q, drop_d;
  logic             started_q;

  logic [DEPTH-1:0][31:0] ent_pc, ent_inst;
  logic [DEPTH-1:0]       ent_filled;
  logic [DEPTH-1:0]       alloc_en, fill_en, pop_en;

  logic [PTR_W-1:0] occ;
  logic             req_hs, resp_fill, resp_drop, pop;

  // Occupancy counts allocated entries, so a full queue stops issuing even
  // while responses are still outstanding.
  assign occ           = alloc_q - rd_q;
  assign mem_req_valid = started_q & ~redirect_valid & (occ < DEPTH_P);
  assign mem_req_addr  = fetch_pc_q;
  assign req_hs        = mem_req_valid & mem_req_ready;

  // Stale responses are swallowed while drop_q is nonzero; a response landing
  // in the redirect cycle is accounted for in drop_d instead of being stored.
  assign resp_drop = mem_resp_valid & (drop_q != '0);
  assign resp_fill = mem_resp_valid & (drop_q == '0) & ~redirect_valid;

  assign out_valid = ent_filled[rd_q[IDX_W-1:0]] & (rd_q != alloc_q);
  assign out_pc    = ent_pc[rd_q[IDX_W-1:0]];
  assign out_inst  = ent_inst[rd_q[IDX_W-1:0]];
  assign pop       = out_valid & out_ready;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      assign alloc_en[i] = req_hs    & (alloc_q[IDX_W-1:0] == IDX_W'(i));
      assign fill_en[i]  = resp_fill & (fill_q[IDX_W-1:0]  == IDX_W'(i));
      assign pop_en[i]   = pop       & (rd_q[IDX_W-1:0]    == IDX_W'(i));

      ifu_fq_entry u_ent (
        .clk        (clk),
        .rst        (rst),
        .alloc_en_i (alloc_en[i]),
        .pc_i       (fetch_pc_q),
        .fill_en_i  (fill_en[i]),
        .inst_i     (mem_resp_data),
        .pop_en_i   (pop_en[i]),
        .flush_i    (redirect_valid),
        .pc_o       (ent_pc[i]),
        .inst_o     (ent_inst[i]),
        .filled_o   (ent_filled[i])
      );
    end
  endgenerate

  // Pointer / fetch-pc / drop-count next state; redirect overrides everything
  // but still carries forward every response that has yet to arrive.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    rd_d       = rd_q;
    drop_d     = drop_q;
    if (req_hs) begin
      alloc_d    = alloc_q + 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (resp_fill) fill_d = fill_q + 1'b1;
    if (resp_drop) drop_d = drop_q - 1'b1;
    if (pop)       rd_d   = rd_q + 1'b1;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      alloc_d    = '0;
      fill_d     = '0;
      rd_d       = '0;
      drop_d     = drop_q + (alloc_q - fill_q) - {{(PTR_W-1){1'b0}}, mem_resp_valid};
    end
  end

  // Control registers; started_q delays the first request by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      alloc_q    <= '0;
      fill_q     <= '0;
      rd_q       <= '0;
      drop_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      rd_q       <= rd_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed and randomized-handshake bench for ifu_fetch_queue with an
// in-order memory model of configurable latency.
module tb_ifu_fetch_queue;
  logic        clk;
  logic        rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_pass = 0;
  int n_total = 0;

  // memory model state
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc;
  int          mem_lat;

  // per-step samples
  logic        s_req_v, s_req_hs, s_out_v, s_pop;
  logic [31:0] s_req_a, s_pc, s_inst;

  ifu_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One cycle: drive inputs at negedge, sample 1 ns later, log handshakes.
  task automatic step(input logic mrdy, input logic ordy, input logic rv, input logic [31:0] rpc);
    int d;
    @(negedge clk);
    mem_req_ready  = mrdy;
    out_ready      = ordy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    #1;
    s_req_v  = mem_req_valid;
    s_req_a  = mem_req_addr;
    s_out_v  = out_valid;
    s_pc     = out_pc;
    s_inst   = out_inst;
    s_req_hs = mem_req_valid & mrdy;
    s_pop    = out_valid & ordy;
    if (s_req_hs) begin
      d = cyc + mem_lat;
      if (pend_due.size() > 0 && d <= pend_due[$]) d = pend_due[$] + 1;
      pend_addr.push_back(mem_req_addr);
      pend_due.push_back(d);
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    pend_addr.delete();
    pend_due.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", mem_req_valid); else n_pass++;
    n_total++; if (mem_req_addr !== 32'h8000_0000) $display("FAIL reset_req_addr got %h want 80000000", mem_req_addr); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_pc !== 32'h0) $display("FAIL reset_out_pc got %h want 0", out_pc); else n_pass++;
    n_total++; if (out_inst !== 32'h0) $display("FAIL reset_out_inst got %h want 0", out_inst); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] ea, ep;
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      ea = 32'h8000_0000 + 32'(4 * k);
      n_total++;
      if ({s_req_v, s_req_a} !== {1'b1, ea}) $display("FAIL stream_req k=%0d got %b/%h want 1/%h", k, s_req_v, s_req_a, ea);
      else n_pass++;
      if (k < 2) begin
        n_total++; if (s_out_v !== 1'b0) $display("FAIL stream_early_out k=%0d got %b want 0", k, s_out_v); else n_pass++;
      end else begin
        ep = 32'h8000_0000 + 32'(4 * (k - 2));
        n_total++;
        if ({s_out_v, s_pc, s_inst} !== {1'b1, ep, mem_word(ep)})
          $display("FAIL stream_out k=%0d got %b/%h/%h want 1/%h/%h", k, s_out_v, s_pc, s_inst, ep, mem_word(ep));
        else n_pass++;
      end
    end
  endtask

  task automatic test_full();
    int cnt;
    logic [31:0] ep;
    do_reset();
    mem_lat = 1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      if (s_req_hs) cnt++;
    end
    n_total++; if (cnt !== 4) $display("FAIL full_req_count got %0d want 4", cnt); else n_pass++;
    n_total++; if (s_req_v !== 1'b0) $display("FAIL full_req_stalled got %b want 0", s_req_v); else n_pass++;
    n_total++; if ({s_out_v, s_pc} !== {1'b1, 32'h8000_0000}) $display("FAIL full_head got %b/%h want 1/80000000", s_out_v, s_pc); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      ep = 32'h8000_0000 + 32'(4 * k);
      n_total++;
      if ({s_pop, s_pc, s_inst} !== {1'b1, ep, mem_word(ep)})
        $display("FAIL full_pop k=%0d got %b/%h/%h want 1/%h/%h", k, s_pop, s_pc, s_inst, ep, mem_word(ep));
      else n_pass++;
      if (k == 0) begin
        n_total++; if (s_req_v !== 1'b0) $display("FAIL full_no_req_on_pop got %b want 0", s_req_v); else n_pass++;
      end
      if (k == 1) begin
        n_total++;
        if ({s_req_v, s_req_a} !== {1'b1, 32'h8000_0010}) $display("FAIL full_resume got %b/%h want 1/80000010", s_req_v, s_req_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_lat = 4;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h8000_1002);
    n_total++; if (s_req_v !== 1'b0) $display("FAIL redir_no_req got %b want 0", s_req_v); else n_pass++;
    for (int k = 4; k < 9; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      if (k == 4) begin
        n_total++;
        if ({s_req_v, s_req_a} !== {1'b1, 32'h8000_1000}) $display("FAIL redir_first_req got %b/%h want 1/80001000", s_req_v, s_req_a);
        else n_pass++;
      end
      n_total++; if (s_out_v !== 1'b0) $display("FAIL redir_stale_out k=%0d got %b want 0", k, s_out_v); else n_pass++;
    end
    step(1'b1, 1'b1, 1'b0, '0);
    n_total++;
    if ({s_out_v, s_pc, s_inst} !== {1'b1, 32'h8000_1000, mem_word(32'h8000_1000)})
      $display("FAIL redir_first_out got %b/%h/%h want 1/80001000/%h", s_out_v, s_pc, s_inst, mem_word(32'h8000_1000));
    else n_pass++;
  endtask

  task automatic test_redirect_resp();
    do_reset();
    mem_lat = 2;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_2000);
    n_total++; if (s_req_v !== 1'b0) $display("FAIL rresp_no_req got %b want 0", s_req_v); else n_pass++;
    step(1'b1, 1'b1, 1'b0, '0);
    n_total++;
    if ({s_req_v, s_req_a} !== {1'b1, 32'h8000_2000}) $display("FAIL rresp_req got %b/%h want 1/80002000", s_req_v, s_req_a);
    else n_pass++;
    for (int k = 4; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      n_total++; if (s_out_v !== 1'b0) $display("FAIL rresp_stale_out k=%0d got %b want 0", k, s_out_v); else n_pass++;
    end
    step(1'b1, 1'b1, 1'b0, '0);
    n_total++;
    if ({s_out_v, s_pc, s_inst} !== {1'b1, 32'h8000_2000, mem_word(32'h8000_2000)})
      $display("FAIL rresp_out0 got %b/%h/%h want 1/80002000/%h", s_out_v, s_pc, s_inst, mem_word(32'h8000_2000));
    else n_pass++;
    step(1'b1, 1'b1, 1'b0, '0);
    n_total++;
    if ({s_out_v, s_pc, s_inst} !== {1'b1, 32'h8000_2004, mem_word(32'h8000_2004)})
      $display("FAIL rresp_out1 got %b/%h/%h want 1/80002004/%h", s_out_v, s_pc, s_inst, mem_word(32'h8000_2004));
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] ep;
    int pops;
    do_reset();
    ep = 32'h8000_0000;
    pops = 0;
    for (int k = 0; k < 5000; k++) begin
      mem_lat = $urandom_range(1, 3);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 1'b0, '0);
      if (s_pop) begin
        n_total++;
        if ({s_pc, s_inst} !== {ep, mem_word(ep)}) begin
          $display("FAIL random_pop n=%0d got %h/%h want %h/%h", pops, s_pc, s_inst, ep, mem_word(ep));
          break;
        end
        n_pass++;
        ep = ep + 32'd4;
        pops++;
      end
    end
    n_total++; if (pops < 1000) $display("FAIL random_throughput got %0d pops want >=1000", pops); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_lat = 1;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, '0);
    n_total++; if (s_out_v !== 1'b1) $display("FAIL rmid_pre_valid got %b want 1", s_out_v); else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (mem_req_valid !== 1'b0) $display("FAIL rmid_req_valid got %b want 0", mem_req_valid); else n_pass++;
    n_total++; if (mem_req_addr !== 32'h8000_0000) $display("FAIL rmid_req_addr got %h want 80000000", mem_req_addr); else n_pass++;
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    n_total++;
    if ({s_req_v, s_req_a} !== {1'b1, 32'h8000_0000}) $display("FAIL rmid_restart got %b/%h want 1/80000000", s_req_v, s_req_a);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b0;
    mem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    cyc = 0;
    mem_lat = 1;
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_redirect_resp();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
